add_round_key_pipe: RTL
=======================

# add_round_key_pipe

Parametrised, registered AddRoundKey stage with an internal round-key bank and valid/ready flow control. Successor to the combinational XOR stage used in the AES128 CBC datapath. Stores up to NUM_KEYS expanded round keys, selects one per transfer by round index (optionally reversed for decryption), XORs it into the state and presents the result one cycle later. Sits between the key-expansion unit (writes keys) and the round datapath (streams states).

## Interface
- DATA_W, 128, state/key width in bits
- NUM_KEYS, 11, round keys stored (AES-128: 11)
- IDX_W, 4, round index width; NUM_KEYS <= 2**IDX_W
- REVERSE, 0, 1 = effective key index is NUM_KEYS-1-round (decrypt order)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- key_wr_en  in  1  write key_wr_data into bank entry key_wr_idx
- key_wr_idx  in  IDX_W  physical bank index, not REVERSE-mapped
- key_wr_data  in  DATA_W  round key
- key_clear  in  1  invalidate all bank entries
- keys_loaded  out  1  all NUM_KEYS entries valid
- in_valid  in  1  input state present
- in_ready  out  1  stage accepts input
- in_state  in  DATA_W  state to combine
- in_round  in  IDX_W  logical round number
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- out_state  out  DATA_W  in_state ^ selected key
- out_round  out  IDX_W  in_round of that result
- out_err  out  1  result produced without a valid key

## Operation
- Bank: NUM_KEYS x DATA_W registers plus NUM_KEYS-bit valid vector. Key data is not reset; the valid vector is.
- key_wr_en with key_wr_idx < NUM_KEYS: store data, set valid bit. key_wr_idx >= NUM_KEYS: ignored.
- key_clear: clear every valid bit. key_clear together with key_wr_en: clear wins, the write is dropped.
- Effective index eff = REVERSE ? NUM_KEYS-1-in_round : in_round, computed only when in_round < NUM_KEYS.
- Input accepted when in_valid && in_ready. On acceptance:
  - key hit (in_round < NUM_KEYS and entry eff valid after this cycle's bank update): out_state <= in_state ^ key, out_err <= 0.
  - otherwise: out_state <= in_state unchanged, out_err <= 1.
  - out_round <= in_round, out_valid <= 1.
- Write bypass: a key_wr_en to entry eff in the acceptance cycle supplies key_wr_data and counts as valid. key_clear in the acceptance cycle makes the lookup miss (out_err=1).
- Output register holds value while out_valid && !out_ready.
- keys_loaded = AND of valid vector, registered from the updated vector.

## Timing
- Reset values: out_valid=0, out_state=0, out_round=0, out_err=0, keys_loaded=0, valid vector=0. in_ready=1 in the cycle after reset deasserts.
- in_ready = !out_valid || out_ready (combinational from out_ready; no in->out combinational path).
- Latency 1 cycle: input accepted at edge N appears on out_* after edge N. Throughput 1 transfer/cycle under continuous out_ready.
- out_valid clears at a handshake edge if no new input is accepted in the same cycle. Simultaneous output handshake and input acceptance replaces the register with no bubble.
- out_state/out_round/out_err stable while out_valid && !out_ready. Key writes during a stall do not alter the held result.
- keys_loaded updates one cycle after the write/clear that changes it.
- reset mid-stream: pending output discarded (out_valid=0), all keys invalidated, writes and input in the reset cycle ignored.

## Test plan
- Load entry 0 = 2b7e151628aed2a6abf7158809cf4f3c; send state 3243f6a8885a308d313198a2e0370734, round 0 -> next cycle out_state 193de3bea0f4e22b9ac68d2ae9f84808, out_round 0, out_err 0.
- REVERSE=1, NUM_KEYS=11: write entry 10 = all-ones, send state 0, round 0 -> out_state all-ones. Send round 11 -> out_state 0, out_err 1.
- Load 11 keys one per cycle -> keys_loaded rises one cycle after the 11th write. Assert key_clear alone -> keys_loaded 0 next cycle. key_clear with key_wr_en -> write dropped.
- Stream 8 states back-to-back with out_ready held 0 for 3 cycles mid-stream -> in_ready low while stalled, no data lost or duplicated, output order preserved, held output constant.
- Input round 3 accepted in the same cycle entry 3 is first written with 0x...01 -> result uses the new key, out_err 0. Same with key_clear asserted instead -> passthrough, out_err 1.
- Assert reset while out_valid=1 and stalled -> out_valid 0, keys_loaded 0 next cycle. A subsequent lookup of any round -> out_err 1.

Source files
------------

// File: rtl/add_round_key_pipe.sv
// Registered AddRoundKey stage: a small round-key bank with write bypass, selected by
// logical round (optionally reversed), XORed into the state behind a valid/ready output register.
module add_round_key_pipe #(
  parameter int DATA_W   = 128,
  parameter int NUM_KEYS = 11,
  parameter int IDX_W    = 4,
  parameter int REVERSE  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_wr_en,
  input  logic [IDX_W-1:0]  key_wr_idx,
  input  logic [DATA_W-1:0] key_wr_data,
  input  logic              key_clear,
  output logic              keys_loaded,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_state,
  input  logic [IDX_W-1:0]  in_round,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_state,
  output logic [IDX_W-1:0]  out_round,
  output logic              out_err
);

  localparam logic [IDX_W:0]   NUM_KEYS_W = (IDX_W+1)'(NUM_KEYS);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_KEYS - 1);

  logic [DATA_W-1:0]   key_mem_q [NUM_KEYS];
  logic [NUM_KEYS-1:0] key_valid_q;
  logic [NUM_KEYS-1:0] key_valid_d;
  logic                keys_loaded_q;

  logic                out_valid_q;
  logic [DATA_W-1:0]   out_state_q;
  logic [DATA_W-1:0]   out_state_d;
  logic [IDX_W-1:0]    out_round_q;
  logic                out_err_q;
  logic                out_err_d;

  logic                wr_in_range;
  logic                wr_commit;
  logic                round_in_range;
  logic [IDX_W-1:0]    eff_idx;
  logic [DATA_W-1:0]   bank_key;
  logic                bank_valid;
  logic                bypass_hit;
  logic [DATA_W-1:0]   sel_key;
  logic                key_hit;
  logic                accept;

  // A clear in the same cycle as a write wins, so the write never commits.
  assign wr_in_range    = {1'b0, key_wr_idx} < NUM_KEYS_W;
  assign wr_commit      = key_wr_en && wr_in_range && !key_clear;
  assign round_in_range = {1'b0, in_round} < NUM_KEYS_W;
  assign eff_idx        = (REVERSE != 0) ? (LAST_IDX - in_round) : in_round;

  always_comb begin
    bank_key   = '0;
    bank_valid = 1'b0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (eff_idx == IDX_W'(k)) begin
        bank_key   = key_mem_q[k];
        bank_valid = key_valid_q[k];
      end
    end
  end

  // Lookup sees the bank as it will be after this cycle's update.
  assign bypass_hit = wr_commit && (key_wr_idx == eff_idx);
  assign sel_key    = bypass_hit ? key_wr_data : bank_key;
  assign key_hit    = round_in_range && !key_clear && (bypass_hit || bank_valid);

  assign out_state_d = key_hit ? (in_state ^ sel_key) : in_state;
  assign out_err_d   = !key_hit;

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_valid
      assign key_valid_d[gi] = !key_clear &&
                               (key_valid_q[gi] || (wr_commit && key_wr_idx == IDX_W'(gi)));
    end
  endgenerate

  // Key data is deliberately left unreset; only the valid vector gates its use.
  always_ff @(posedge clk) begin
    if (!reset && wr_commit) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (key_wr_idx == IDX_W'(k)) key_mem_q[k] <= key_wr_data;
      end
    end
  end

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_valid_q   <= '0;
      keys_loaded_q <= 1'b0;
      out_valid_q   <= 1'b0;
      out_state_q   <= '0;
      out_round_q   <= '0;
      out_err_q     <= 1'b0;
    end else begin
      key_valid_q   <= key_valid_d;
      keys_loaded_q <= &key_valid_d;
      if (accept) begin
        out_valid_q <= 1'b1;
        out_state_q <= out_state_d;
        out_round_q <= in_round;
        out_err_q   <= out_err_d;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign keys_loaded = keys_loaded_q;
  assign out_valid   = out_valid_q;
  assign out_state   = out_state_q;
  assign out_round   = out_round_q;
  assign out_err     = out_err_q;

endmodule
